// File: rtl/g2_update_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : g2_update_ctrl                                                  |
// | Purpose  : Write-side controller for one G2 rule table. Accepts            |
// |            INSERT / DELETE / CLEAR / NOP requests over valid/ready, tracks |
// |            slot occupancy with a bitmap, allocates the lowest free slot,   |
// |            packs entry words and drives the table write port.             |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            req_*        : request handshake and payload from update host   |
// |            we/din/wr_index : table write port                             |
// |            upd_busy     : controller owns the table index port            |
// |            resp_*       : one-cycle completion pulse, status, index        |
// |            free_count   : unallocated entries among 1..TABLE_ENTRY_SIZE    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module g2_update_ctrl #(
  parameter int TABLE_ENTRY_SIZE = 18,
  parameter int INDEX_BIT_LEN    = 11,
  parameter int ENTRY_DATA_WIDTH = 98,
  parameter int COMMAND_BIT_LEN  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [COMMAND_BIT_LEN-1:0]  req_cmd,
  input  logic [31:0]                 req_src_ip,
  input  logic [31:0]                 req_dst_ip,
  input  logic [INDEX_BIT_LEN-1:0]    req_rule_id,
  input  logic [INDEX_BIT_LEN-1:0]    req_next_index,
  input  logic [INDEX_BIT_LEN-1:0]    req_index,
  output logic                        we,
  output logic [ENTRY_DATA_WIDTH-1:0] din,
  output logic [INDEX_BIT_LEN-1:0]    wr_index,
  output logic                        upd_busy,
  output logic                        resp_valid,
  output logic [1:0]                  resp_status,
  output logic [INDEX_BIT_LEN-1:0]    resp_index,
  output logic [INDEX_BIT_LEN-1:0]    free_count
);

  localparam int c_MAP_W = TABLE_ENTRY_SIZE + 1;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_WRITE = 2'd1;
  localparam logic [1:0] c_ST_CLEAR = 2'd2;
  localparam logic [1:0] c_ST_RESP  = 2'd3;

  localparam logic [COMMAND_BIT_LEN-1:0] c_CMD_NOP    = COMMAND_BIT_LEN'(0);
  localparam logic [COMMAND_BIT_LEN-1:0] c_CMD_INSERT = COMMAND_BIT_LEN'(1);
  localparam logic [COMMAND_BIT_LEN-1:0] c_CMD_DELETE = COMMAND_BIT_LEN'(2);
  localparam logic [COMMAND_BIT_LEN-1:0] c_CMD_CLEAR  = COMMAND_BIT_LEN'(3);

  localparam logic [1:0] c_RS_OK        = 2'b00;
  localparam logic [1:0] c_RS_FULL      = 2'b01;
  localparam logic [1:0] c_RS_BAD_INDEX = 2'b10;
  localparam logic [1:0] c_RS_NOT_ALLOC = 2'b11;

  localparam logic [INDEX_BIT_LEN-1:0] c_LAST_INDEX = INDEX_BIT_LEN'(TABLE_ENTRY_SIZE);
  localparam logic [INDEX_BIT_LEN-1:0] c_ONE        = INDEX_BIT_LEN'(1);
  localparam logic [c_MAP_W-1:0]       c_MAP_RESET  = c_MAP_W'(1);

  logic [1:0]                  r_state, w_state_nxt;
  logic [c_MAP_W-1:0]          r_bitmap, w_bitmap_d;
  logic [INDEX_BIT_LEN-1:0]    r_free_count, w_free_count_d;
  logic                        r_is_insert, w_is_insert_d;
  logic [INDEX_BIT_LEN-1:0]    r_target, w_target_d;
  logic                        r_we, w_we_d;
  logic [ENTRY_DATA_WIDTH-1:0] r_din, w_din_d;
  logic [INDEX_BIT_LEN-1:0]    r_wr_index, w_wr_index_d;
  logic                        r_resp_valid, w_resp_valid_d;
  logic [1:0]                  r_resp_status, w_resp_status_d;
  logic [INDEX_BIT_LEN-1:0]    r_resp_index, w_resp_index_d;

  logic                        w_alloc_found;
  logic [INDEX_BIT_LEN-1:0]    w_alloc_index;
  logic                        w_del_bad;
  logic                        w_del_alloc;
  logic [ENTRY_DATA_WIDTH-1:0] w_entry;

  assign w_entry = {req_next_index, req_rule_id, 6'b0, req_dst_ip, 6'b0, req_src_ip};

  // Lowest clear bitmap bit wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_alloc_found = 1'b0;
    w_alloc_index = '0;
    for (int i = TABLE_ENTRY_SIZE; i >= 1; i--) begin
      if (!r_bitmap[i]) begin
        w_alloc_found = 1'b1;
        w_alloc_index = INDEX_BIT_LEN'(i);
      end
    end
  end

  // The request index is wider than the bitmap, so look the bit up by
  // comparison rather than by direct selection.
  always_comb begin
    w_del_bad   = (req_index == '0) || (req_index > c_LAST_INDEX);
    w_del_alloc = 1'b0;
    for (int i = 0; i <= TABLE_ENTRY_SIZE; i++) begin
      if (req_index == INDEX_BIT_LEN'(i)) begin
        w_del_alloc = r_bitmap[i];
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_ST_IDLE;
      r_bitmap      <= c_MAP_RESET;
      r_free_count  <= c_LAST_INDEX;
      r_is_insert   <= 1'b0;
      r_target      <= '0;
      r_we          <= 1'b0;
      r_din         <= '0;
      r_wr_index    <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_status <= c_RS_OK;
      r_resp_index  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_bitmap      <= w_bitmap_d;
      r_free_count  <= w_free_count_d;
      r_is_insert   <= w_is_insert_d;
      r_target      <= w_target_d;
      r_we          <= w_we_d;
      r_din         <= w_din_d;
      r_wr_index    <= w_wr_index_d;
      r_resp_valid  <= w_resp_valid_d;
      r_resp_status <= w_resp_status_d;
      r_resp_index  <= w_resp_index_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (req_valid) begin
          case (req_cmd)
            c_CMD_INSERT: w_state_nxt = w_alloc_found ? c_ST_WRITE : c_ST_RESP;
            c_CMD_DELETE: w_state_nxt = (w_del_bad || !w_del_alloc) ? c_ST_RESP : c_ST_WRITE;
            c_CMD_CLEAR:  w_state_nxt = c_ST_CLEAR;
            default:      w_state_nxt = c_ST_RESP;
          endcase
        end
      end
      c_ST_WRITE: w_state_nxt = c_ST_RESP;
      c_ST_CLEAR: if (r_wr_index == c_LAST_INDEX) w_state_nxt = c_ST_RESP;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output / datapath next values. Write-port outputs are loaded on the
  // accepting edge so the write lands in the very next cycle.
  always_comb begin
    w_we_d          = 1'b0;
    w_din_d         = '0;
    w_wr_index_d    = '0;
    w_resp_valid_d  = 1'b0;
    w_resp_status_d = r_resp_status;
    w_resp_index_d  = r_resp_index;
    w_is_insert_d   = r_is_insert;
    w_target_d      = r_target;
    w_bitmap_d      = r_bitmap;
    w_free_count_d  = r_free_count;
    case (r_state)
      c_ST_IDLE: begin
        if (req_valid) begin
          w_is_insert_d = (req_cmd == c_CMD_INSERT);
          case (req_cmd)
            c_CMD_NOP: begin
              w_resp_valid_d  = 1'b1;
              w_resp_status_d = c_RS_OK;
              w_resp_index_d  = '0;
            end
            c_CMD_INSERT: begin
              if (w_alloc_found) begin
                w_we_d       = 1'b1;
                w_din_d      = w_entry;
                w_wr_index_d = w_alloc_index;
                w_target_d   = w_alloc_index;
              end else begin
                w_resp_valid_d  = 1'b1;
                w_resp_status_d = c_RS_FULL;
                w_resp_index_d  = '0;
              end
            end
            c_CMD_DELETE: begin
              if (w_del_bad || !w_del_alloc) begin
                w_resp_valid_d  = 1'b1;
                w_resp_status_d = w_del_bad ? c_RS_BAD_INDEX : c_RS_NOT_ALLOC;
                w_resp_index_d  = req_index;
              end else begin
                w_we_d       = 1'b1;
                w_wr_index_d = req_index;
                w_target_d   = req_index;
              end
            end
            default: begin
              // CLEAR: first zero write goes to index 0; wr_index then doubles
              // as the sweep counter.
              w_we_d       = 1'b1;
              w_wr_index_d = '0;
            end
          endcase
        end
      end
      c_ST_WRITE: begin
        w_resp_valid_d  = 1'b1;
        w_resp_status_d = c_RS_OK;
        w_resp_index_d  = r_target;
        for (int i = 1; i <= TABLE_ENTRY_SIZE; i++) begin
          if (r_target == INDEX_BIT_LEN'(i)) begin
            w_bitmap_d[i] = r_is_insert;
          end
        end
        if (r_is_insert) begin
          if (r_free_count != '0) w_free_count_d = r_free_count - c_ONE;
        end else begin
          if (r_free_count != c_LAST_INDEX) w_free_count_d = r_free_count + c_ONE;
        end
      end
      c_ST_CLEAR: begin
        if (r_wr_index == c_LAST_INDEX) begin
          w_resp_valid_d  = 1'b1;
          w_resp_status_d = c_RS_OK;
          w_resp_index_d  = '0;
          w_bitmap_d      = c_MAP_RESET;
          w_free_count_d  = c_LAST_INDEX;
        end else begin
          w_we_d       = 1'b1;
          w_wr_index_d = r_wr_index + c_ONE;
        end
      end
      default: begin
      end
    endcase
  end

  assign req_ready   = (r_state == c_ST_IDLE);
  assign upd_busy    = (r_state == c_ST_WRITE) || (r_state == c_ST_CLEAR);
  assign we          = r_we;
  assign din         = r_din;
  assign wr_index    = r_wr_index;
  assign resp_valid  = r_resp_valid;
  assign resp_status = r_resp_status;
  assign resp_index  = r_resp_index;
  assign free_count  = r_free_count;

endmodule
`default_nettype wire

// File: tb/tb_g2_update_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_g2_update_ctrl                                               |
// | Purpose  : Self-checking bench for g2_update_ctrl. A transaction-level     |
// |            model predicts, at each accepted request, the exact sequence of |
// |            output cycles that must follow; a compare process checks every  |
// |            cycle. Directed scenarios pin the model with literal values,    |
// |            then randomized traffic runs against it.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_g2_update_ctrl;

  localparam int TS = 18;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [31:0] req_src_ip;
  logic [31:0] req_dst_ip;
  logic [10:0] req_rule_id;
  logic [10:0] req_next_index;
  logic [10:0] req_index;
  logic        we;
  logic [97:0] din;
  logic [10:0] wr_index;
  logic        upd_busy;
  logic        resp_valid;
  logic [1:0]  resp_status;
  logic [10:0] resp_index;
  logic [10:0] free_count;

  g2_update_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_src_ip(req_src_ip), .req_dst_ip(req_dst_ip),
    .req_rule_id(req_rule_id), .req_next_index(req_next_index),
    .req_index(req_index),
    .we(we), .din(din), .wr_index(wr_index), .upd_busy(upd_busy),
    .resp_valid(resp_valid), .resp_status(resp_status),
    .resp_index(resp_index), .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int cyc_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic        we;
    logic [10:0] idx;
    logic [97:0] din;
    logic        rv;
    logic [1:0]  st;
    logic [10:0] ri;
    logic        ready;
    logic        busy;
    logic [10:0] free;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  logic occ [0:TS];

  function automatic int count_free();
    int c = 0;
    for (int i = 1; i <= TS; i++) if (!occ[i]) c++;
    return c;
  endfunction

  function automatic rec_t mk(logic w, int idx, logic [97:0] d, logic rv, logic [1:0] st,
                              int ri, logic rdy, logic bsy, int fr);
    rec_t r;
    r.we = w; r.idx = 11'(idx); r.din = d; r.rv = rv; r.st = st; r.ri = 11'(ri);
    r.ready = rdy; r.busy = bsy; r.free = 11'(fr);
    return r;
  endfunction

  function automatic rec_t idle_rec();
    return mk(1'b0, 0, '0, 1'b0, 2'b00, 0, 1'b1, 1'b0, count_free());
  endfunction

  task automatic model_reset();
    q.delete();
    occ[0] = 1'b1;
    for (int i = 1; i <= TS; i++) occ[i] = 1'b0;
    cur = idle_rec();
  endtask

  task automatic model_accept();
    int fr;
    int slot;
    int ix;
    fr = count_free();
    ix = int'(req_index);
    case (req_cmd)
      2'd0: q.push_back(mk(0, 0, '0, 1, 2'b00, 0, 0, 0, fr));
      2'd1: begin
        slot = 0;
        for (int i = TS; i >= 1; i--) if (!occ[i]) slot = i;
        if (slot == 0) begin
          q.push_back(mk(0, 0, '0, 1, 2'b01, 0, 0, 0, fr));
        end else begin
          q.push_back(mk(1, slot, {req_next_index, req_rule_id, 6'b0, req_dst_ip, 6'b0, req_src_ip},
                         0, 2'b00, 0, 0, 1, fr));
          occ[slot] = 1'b1;
          q.push_back(mk(0, 0, '0, 1, 2'b00, slot, 0, 0, fr - 1));
        end
      end
      2'd2: begin
        if (ix == 0 || ix > TS) begin
          q.push_back(mk(0, 0, '0, 1, 2'b10, ix, 0, 0, fr));
        end else if (!occ[ix]) begin
          q.push_back(mk(0, 0, '0, 1, 2'b11, ix, 0, 0, fr));
        end else begin
          q.push_back(mk(1, ix, '0, 0, 2'b00, 0, 0, 1, fr));
          occ[ix] = 1'b0;
          q.push_back(mk(0, 0, '0, 1, 2'b00, ix, 0, 0, fr + 1));
        end
      end
      default: begin
        for (int k = 0; k <= TS; k++) q.push_back(mk(1, k, '0, 0, 2'b00, 0, 0, 1, fr));
        for (int i = 1; i <= TS; i++) occ[i] = 1'b0;
        q.push_back(mk(0, 0, '0, 1, 2'b00, 0, 0, 0, TS));
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (cur.ready && req_valid) begin
          model_accept();
          n_acc++;
        end
        if (q.size() > 0) cur = q.pop_front();
        else              cur = idle_rec();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("req_ready",  req_ready,  cur.ready);
    chk("upd_busy",   upd_busy,   cur.busy);
    chk("we",         we,         cur.we);
    chk("resp_valid", resp_valid, cur.rv);
    chk("free_count", free_count, cur.free);
    if (cur.we) begin
      chk("wr_index", wr_index, cur.idx);
      chk("din",      din,      cur.din);
    end
    if (cur.rv) begin
      chk("resp_status", resp_status, cur.st);
      chk("resp_index",  resp_index,  cur.ri);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] c, input logic [31:0] s, input logic [31:0] d,
                      input logic [10:0] r, input logic [10:0] nx, input logic [10:0] ix,
                      output int t_acc);
    int  start;
    bit  got;
    start = n_acc;
    got   = 1'b0;
    t_acc = 0;
    req_cmd = c; req_src_ip = s; req_dst_ip = d;
    req_rule_id = r; req_next_index = nx; req_index = ix;
    req_valid = 1'b1;
    for (int k = 0; k < 80 && !got; k++) begin
      @(posedge clk);
      t_acc = cyc_cnt;
      #1;
      if (n_acc != start) got = 1'b1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout actual=none required=accept cmd=%0d", c);
    end
  endtask

  task automatic wait_resp(output logic [1:0] st, output logic [10:0] ri, output int wec,
                           output int cyc, output logic [10:0] widx, output logic [97:0] wdin);
    bit got;
    got = 1'b0; st = 2'b00; ri = '0; wec = 0; cyc = 0; widx = '0; wdin = '0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      cyc = k + 1;
      if (we) begin wec++; widx = wr_index; wdin = din; end
      if (resp_valid) begin st = resp_status; ri = resp_index; got = 1'b1; end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL resp_timeout actual=none required=resp_valid");
    end
  endtask

  task automatic txn(input logic [1:0] c, input logic [31:0] s, input logic [31:0] d,
                     input logic [10:0] r, input logic [10:0] nx, input logic [10:0] ix,
                     output logic [1:0] st, output logic [10:0] ri, output int wec,
                     output int cyc, output logic [10:0] widx, output logic [97:0] wdin);
    int ta;
    send(c, s, d, r, nx, ix, ta);
    req_valid = 1'b0;
    wait_resp(st, ri, wec, cyc, widx, wdin);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  st;
    logic [10:0] ri, widx;
    logic [97:0] wdin;
    int          wec, cyc, t1, t2, gap;

    rst_n = 1'b1; req_valid = 1'b0; req_cmd = 2'b00;
    req_src_ip = '0; req_dst_ip = '0; req_rule_id = '0; req_next_index = '0; req_index = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we", we, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_free", free_count, 11'd18);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_busy", upd_busy, 1'b0);
    chk("rst_din", din, 98'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // CLEAR sweep
    txn(2'd3, 0, 0, 0, 0, 0, st, ri, wec, cyc, widx, wdin);
    chk("clr_writes", wec, 19);
    chk("clr_last_idx", widx, 11'd18);
    chk("clr_status", st, 2'b00);
    chk("clr_latency", cyc, 20);
    chk("clr_free", free_count, 11'd18);

    // First insert, literal field check
    txn(2'd1, 32'hC0A80001, 32'h0A000002, 11'd5, 11'd0, 11'd0, st, ri, wec, cyc, widx, wdin);
    chk("ins1_idx", widx, 11'd1);
    chk("ins1_src", wdin[31:0], 32'hC0A80001);
    chk("ins1_dst", wdin[69:38], 32'h0A000002);
    chk("ins1_rule", wdin[86:76], 11'd5);
    chk("ins1_next", wdin[97:87], 11'd0);
    chk("ins1_pad", {wdin[75:70], wdin[37:32]}, 12'd0);
    chk("ins1_ri", ri, 11'd1);
    chk("ins1_latency", cyc, 2);

    // Fill the table
    for (int i = 0; i < 17; i++) begin
      txn(2'd1, $urandom, $urandom, 11'($urandom), 11'($urandom), 11'd0, st, ri, wec, cyc, widx, wdin);
      chk("fill_ri", ri, 11'(i + 2));
    end
    chk("full_free", free_count, 11'd0);
    txn(2'd1, 1, 2, 3, 4, 0, st, ri, wec, cyc, widx, wdin);
    chk("full_status", st, 2'b01);
    chk("full_no_we", wec, 0);
    chk("full_latency", cyc, 1);

    // Delete / reinsert / double delete / bad indices
    txn(2'd2, 0, 0, 0, 0, 11'd7, st, ri, wec, cyc, widx, wdin);
    chk("del7_status", st, 2'b00);
    chk("del7_idx", widx, 11'd7);
    chk("del7_din", wdin, 98'd0);
    txn(2'd1, 32'h11111111, 32'h22222222, 11'd9, 11'd3, 11'd0, st, ri, wec, cyc, widx, wdin);
    chk("reins_ri", ri, 11'd7);
    txn(2'd2, 0, 0, 0, 0, 11'd7, st, ri, wec, cyc, widx, wdin);
    txn(2'd2, 0, 0, 0, 0, 11'd7, st, ri, wec, cyc, widx, wdin);
    chk("del7x2_status", st, 2'b11);
    chk("del7x2_no_we", wec, 0);
    txn(2'd2, 0, 0, 0, 0, 11'd0, st, ri, wec, cyc, widx, wdin);
    chk("del0_status", st, 2'b10);
    txn(2'd2, 0, 0, 0, 0, 11'd19, st, ri, wec, cyc, widx, wdin);
    chk("del19_status", st, 2'b10);
    chk("del19_no_we", wec, 0);

    // NOP held high behind a pending insert
    send(2'd1, 32'hA, 32'hB, 11'd1, 11'd2, 11'd0, t1);
    send(2'd0, 0, 0, 0, 0, 0, t2);
    req_valid = 1'b0;
    chk("nop_accept_gap", t2 - t1, 3);
    wait_resp(st, ri, wec, cyc, widx, wdin);
    chk("nop_status", st, 2'b00);
    chk("nop_latency", cyc, 1);

    // Reset during the 10th CLEAR write cycle
    send(2'd3, 0, 0, 0, 0, 0, t1);
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("midclr_we_pre", we, 1'b1);
    chk("midclr_idx_pre", wr_index, 11'd9);
    rst_n = 1'b0;
    #1;
    chk("midclr_we_async", we, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midclr_ready", req_ready, 1'b1);
    chk("midclr_free", free_count, 11'd18);

    // Randomized traffic
    txn(2'd3, 0, 0, 0, 0, 0, st, ri, wec, cyc, widx, wdin);
    for (int it = 0; it < 160; it++) begin
      int          r;
      logic [1:0]  c;
      r = $urandom_range(0, 99);
      c = (r < 6) ? 2'd0 : (r < 52) ? 2'd1 : (r < 96) ? 2'd2 : 2'd3;
      send(c, $urandom, $urandom, 11'($urandom), 11'($urandom), 11'($urandom_range(0, 20)), t1);
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        req_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
